gate_reduce_pipe: RTL and testbench



---
 rtl/gate_pkg.sv | 18 +
 rtl/gate_reduce_lane.sv | 33 +++
 rtl/gate_reduce_pipe.sv | 115 +++++++++++
 tb/tb_gate_reduce_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared mode codes and helpers for the pipelined reduction-gate block.
package gate_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd1;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

  // Codes above XNOR (6 and 7) are reserved.
  function automatic logic is_reserved(input logic [MODE_W-1:0] mode);
    return (mode > MODE_XNOR);
  endfunction

endpackage

// File: rtl/gate_reduce_lane.sv
// One channel: N_IN-input reduction selected by mode; reserved modes yield 0.
module gate_reduce_lane
  import gate_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0]   a_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic              y_o
);

  logic all_ones;
  logic any_one;
  logic parity;

  assign all_ones = &a_i;
  assign any_one  = |a_i;
  assign parity   = ^a_i;

  always_comb begin
    y_o = 1'b0;
    case (mode_i)
      MODE_AND:  y_o = all_ones;
      MODE_NAND: y_o = ~all_ones;
      MODE_OR:   y_o = any_one;
      MODE_NOR:  y_o = ~any_one;
      MODE_XOR:  y_o = parity;
      MODE_XNOR: y_o = ~parity;
      default:   y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_reduce_pipe.sv
// Two-stage valid/ready pipeline of CHANNELS reduction gates, with a sticky
// reserved-mode flag and a saturating completed-beat counter.
module gate_reduce_pipe
  import gate_pkg::*;
#(
  parameter int N_IN     = 3,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNELS*N_IN-1:0] in_data,
  input  logic [MODE_W-1:0]        in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNELS-1:0]      out_y,
  output logic                     mode_err,
  input  logic                     err_clr,
  output logic [CNT_W-1:0]         beat_cnt
);

  // Handshake: a beat transfers on a cycle where valid & ready are both high.
  // Valid never depends on ready; ready flows combinationally upstream so a
  // full pipeline still accepts a beat in the same cycle the sink drains one.

  logic                     s1_valid_q, s1_valid_d;
  logic [CHANNELS*N_IN-1:0] s1_data_q, s1_data_d;
  logic [MODE_W-1:0]        s1_mode_q, s1_mode_d;
  logic                     out_valid_q, out_valid_d;
  logic [CHANNELS-1:0]      out_y_q, out_y_d;
  logic                     mode_err_q, mode_err_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;

  logic                s2_ready;
  logic                in_hs;
  logic                s1_move;
  logic                out_hs;
  logic [CHANNELS-1:0] y_next;

  assign s2_ready = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_ready;
  assign in_hs    = in_valid & in_ready;
  assign s1_move  = s1_valid_q & s2_ready;
  assign out_hs   = out_valid_q & out_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    gate_reduce_lane #(.N_IN(N_IN)) u_lane (
      .a_i    (s1_data_q[k*N_IN +: N_IN]),
      .mode_i (s1_mode_q),
      .y_o    (y_next[k])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_mode_d  = in_mode;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 only changes when it can accept; out_y holds through empty cycles.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_y_d = y_next;
    end
  end

  // Set has priority over a coincident clear.
  always_comb begin
    mode_err_d = mode_err_q & ~err_clr;
    if (s1_move && is_reserved(s1_mode_q)) mode_err_d = 1'b1;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_hs && !(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      mode_err_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      mode_err_q  <= mode_err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign mode_err  = mode_err_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Directed bench for gate_reduce_pipe; a second instance with CNT_W=2 covers
// counter saturation. Inputs change and outputs are sampled on falling edges.
module tb_gate_reduce_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic [2:0]  in_mode;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_y;
  logic        mode_err;
  logic [15:0] beat_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [3:0]  sat_out_y;
  logic        sat_mode_err;
  logic [1:0]  sat_beat_cnt;

  int total;
  int bad;

  gate_reduce_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .mode_err  (mode_err),
    .err_clr   (err_clr),
    .beat_cnt  (beat_cnt)
  );

  gate_reduce_pipe #(.CNT_W(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_y     (sat_out_y),
    .mode_err  (sat_mode_err),
    .err_clr   (err_clr),
    .beat_cnt  (sat_beat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [11:0] d);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
  endtask

  logic [3:0] b2b_exp [6];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 12'h000);
    out_ready = 1'b1;
    err_clr   = 1'b0;
    b2b_exp[0] = 4'b1001;
    b2b_exp[1] = 4'b0110;
    b2b_exp[2] = 4'b1101;
    b2b_exp[3] = 4'b0010;
    b2b_exp[4] = 4'b1001;
    b2b_exp[5] = 4'b0110;
    repeat (3) nxt();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_mode_err", 32'(mode_err), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    nxt();

    // single NAND beat
    drive(1'b1, 3'd1, 12'b111_011_000_111);
    #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
    nxt();
    drive(1'b0, 3'd0, 12'h000);
    chk("t1_lat1_valid", 32'(out_valid), 32'd0);
    nxt();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_out_y", 32'(out_y), 32'b0110);
    nxt();
    chk("t1_beat_cnt", 32'(beat_cnt), 32'd1);
    chk("t1_drained", 32'(out_valid), 32'd0);

    // back-to-back, one beat per mode 0..5
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) begin
        chk($sformatf("b2b_valid%0d", i - 2), 32'(out_valid), 32'd1);
        chk($sformatf("b2b_y%0d", i - 2), 32'(out_y), 32'(b2b_exp[i-2]));
      end
      if (i < 6) drive(1'b1, 3'(i), 12'b111_101_000_111);
      else drive(1'b0, 3'd0, 12'h000);
      nxt();
    end
    chk("b2b_drained", 32'(out_valid), 32'd0);
    chk("b2b_beat_cnt", 32'(beat_cnt), 32'd7);

    // backpressure: A=AND(fff)->1111, B=OR(000)->0000, C=XOR(001)->0001
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 12'hfff);
    #1 chk("bp_rdyA", 32'(in_ready), 32'd1);
    nxt();
    drive(1'b1, 3'd2, 12'h000);
    #1 chk("bp_rdyB", 32'(in_ready), 32'd1);
    nxt();
    drive(1'b1, 3'd4, 12'h001);
    #1 chk("bp_rdyC_stalled", 32'(in_ready), 32'd0);
    chk("bp_A_valid", 32'(out_valid), 32'd1);
    chk("bp_A_y", 32'(out_y), 32'b1111);
    nxt();
    chk("bp_rdy_still0", 32'(in_ready), 32'd0);
    chk("bp_A_hold", 32'(out_y), 32'b1111);
    chk("bp_valid_hold", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", 32'(in_ready), 32'd1);
    nxt();
    drive(1'b0, 3'd0, 12'h000);
    chk("bp_B_valid", 32'(out_valid), 32'd1);
    chk("bp_B_y", 32'(out_y), 32'b0000);
    nxt();
    chk("bp_C_valid", 32'(out_valid), 32'd1);
    chk("bp_C_y", 32'(out_y), 32'b0001);
    nxt();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_beat_cnt", 32'(beat_cnt), 32'd10);

    // reserved mode and sticky error
    drive(1'b1, 3'd6, 12'hfff);
    nxt();
    drive(1'b0, 3'd0, 12'h000);
    chk("rsv_err_before_move", 32'(mode_err), 32'd0);
    nxt();
    chk("rsv_valid", 32'(out_valid), 32'd1);
    chk("rsv_y", 32'(out_y), 32'b0000);
    chk("rsv_err_set", 32'(mode_err), 32'd1);
    drive(1'b1, 3'd0, 12'hfff);
    nxt();
    drive(1'b0, 3'd0, 12'h000);
    nxt();
    chk("rsv_next_y", 32'(out_y), 32'b1111);
    chk("rsv_err_sticky", 32'(mode_err), 32'd1);
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    chk("rsv_err_cleared", 32'(mode_err), 32'd0);
    drive(1'b1, 3'd7, 12'hfff);
    nxt();
    drive(1'b0, 3'd0, 12'h000);
    err_clr = 1'b1;
    nxt();
    err_clr = 1'b0;
    chk("rsv_set_wins", 32'(mode_err), 32'd1);
    chk("rsv7_y", 32'(out_y), 32'b0000);
    nxt();
    chk("rsv_err_hold", 32'(mode_err), 32'd1);

    // reset while S1 and S2 are full and stalled
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 12'hfff);
    nxt();
    drive(1'b1, 3'd2, 12'hfff);
    nxt();
    drive(1'b0, 3'd0, 12'h000);
    chk("mid_full_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("mid_mode_err", 32'(mode_err), 32'd0);
    chk("mid_out_y", 32'(out_y), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_sat_cnt", 32'(sat_beat_cnt), 32'd0);
    nxt();
    out_ready = 1'b1;
    rst_n = 1'b1;
    nxt();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    // post-reset latency plus CNT_W=2 saturation over 5 beats (OR, data 001)
    for (int i = 0; i < 8; i++) begin
      if (i == 1) chk("post_lat1", 32'(out_valid), 32'd0);
      if (i == 2) begin
        chk("post_lat2", 32'(out_valid), 32'd1);
        chk("post_y", 32'(out_y), 32'b0001);
      end
      if (i >= 3) begin
        chk($sformatf("sat_cnt%0d", i - 2), 32'(sat_beat_cnt), (i - 2 > 3) ? 32'd3 : 32'(i - 2));
        chk($sformatf("main_cnt%0d", i - 2), 32'(beat_cnt), 32'(i - 2));
      end
      if (i < 5) drive(1'b1, 3'd2, 12'h001);
      else drive(1'b0, 3'd0, 12'h000);
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
